// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto the single memory request
// port and routes tagged memory responses back, with one outstanding read per side.
module mem_arbiter #(
    parameter int TIMEOUT = 32,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int SIZE_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_valid_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic [SIZE_W-1:0] ic_access_size_i,
    output logic              ic_req_ready_o,
    output logic              ic_resp_valid_o,
    output logic [LINE_W-1:0] ic_resp_data_o,
    input  logic              dc_rd_req_valid_i,
    input  logic              dc_wr_req_valid_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wr_data_i,
    input  logic [SIZE_W-1:0] dc_access_size_i,
    output logic              dc_req_ready_o,
    output logic              dc_resp_valid_o,
    output logic [LINE_W-1:0] dc_resp_data_o,
    output logic              mem_rd_req_valid_o,
    output logic              mem_wr_req_valid_o,
    output logic              mem_req_is_instr_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_wr_data_o,
    output logic [SIZE_W-1:0] mem_access_size_o,
    input  logic              mem_data_valid_i,
    input  logic              mem_data_is_instr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO    = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

    logic              ic_busy_q, ic_busy_d, dc_busy_q, dc_busy_d;
    logic              last_grant_q, last_grant_d, err_q, err_d;
    logic [CW-1:0]     ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, mem_instr_q, mem_instr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [SIZE_W-1:0] mem_size_q, mem_size_d;
    logic              ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
    logic [LINE_W-1:0] ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;

    logic ic_elig, dc_elig, dc_illegal, grant_ic, grant_dc;
    logic ic_rsp, dc_rsp, rsp_unexp, ic_to, dc_to;

    assign ic_elig    = ic_req_valid_i && !ic_busy_q;
    assign dc_illegal = dc_rd_req_valid_i && dc_wr_req_valid_i;
    // Writebacks never wait on an outstanding dcache read; memory keeps them ordered.
    assign dc_elig    = !dc_illegal &&
                        ((dc_rd_req_valid_i && !dc_busy_q) || dc_wr_req_valid_i);
    assign grant_ic   = ic_elig && (!dc_elig || last_grant_q);
    assign grant_dc   = dc_elig && (!ic_elig || !last_grant_q);

    assign ic_rsp    = mem_data_valid_i &&  mem_data_is_instr_i && ic_busy_q;
    assign dc_rsp    = mem_data_valid_i && !mem_data_is_instr_i && dc_busy_q;
    assign rsp_unexp = mem_data_valid_i && !ic_rsp && !dc_rsp;
    assign ic_to     = ic_busy_q && (ic_cnt_q == TO_M1);
    assign dc_to     = dc_busy_q && (dc_cnt_q == TO_M1);

    always_comb begin
        mem_rd_d    = grant_ic || (grant_dc && dc_rd_req_valid_i);
        mem_wr_d    = grant_dc && dc_wr_req_valid_i;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if (grant_ic) begin
            mem_instr_d = 1'b1;
            mem_addr_d  = ic_addr_i;
            mem_wdata_d = '0;
            mem_size_d  = ic_access_size_i;
        end else if (grant_dc) begin
            mem_instr_d = 1'b0;
            mem_addr_d  = dc_addr_i;
            mem_wdata_d = dc_wr_req_valid_i ? dc_wr_data_i : '0;
            mem_size_d  = dc_access_size_i;
        end

        ic_rv_d = ic_rsp;
        dc_rv_d = dc_rsp;
        ic_rd_d = ic_rsp ? mem_data_i : ic_rd_q;
        dc_rd_d = dc_rsp ? mem_data_i : dc_rd_q;

        ic_busy_d = grant_ic ? 1'b1 : (ic_rsp ? 1'b0 : ic_busy_q);
        dc_busy_d = (grant_dc && dc_rd_req_valid_i) ? 1'b1 : (dc_rsp ? 1'b0 : dc_busy_q);

        ic_cnt_d = ic_cnt_q;
        if (grant_ic)                           ic_cnt_d = '0;
        else if (ic_busy_q && ic_cnt_q != TO)   ic_cnt_d = ic_cnt_q + 1'b1;
        dc_cnt_d = dc_cnt_q;
        if (grant_dc && dc_rd_req_valid_i)      dc_cnt_d = '0;
        else if (dc_busy_q && dc_cnt_q != TO)   dc_cnt_d = dc_cnt_q + 1'b1;

        last_grant_d = grant_ic ? 1'b0 : (grant_dc ? 1'b1 : last_grant_q);
        err_d        = err_q || rsp_unexp || dc_illegal || ic_to || dc_to;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ic_busy_q    <= 1'b0;
            dc_busy_q    <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            ic_cnt_q     <= '0;
            dc_cnt_q     <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            ic_rv_q      <= 1'b0;
            dc_rv_q      <= 1'b0;
            ic_rd_q      <= '0;
            dc_rd_q      <= '0;
        end else begin
            ic_busy_q    <= ic_busy_d;
            dc_busy_q    <= dc_busy_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            ic_cnt_q     <= ic_cnt_d;
            dc_cnt_q     <= dc_cnt_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_instr_q  <= mem_instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            ic_rv_q      <= ic_rv_d;
            dc_rv_q      <= dc_rv_d;
            ic_rd_q      <= ic_rd_d;
            dc_rd_q      <= dc_rd_d;
        end
    end

    assign ic_req_ready_o     = grant_ic;
    assign dc_req_ready_o     = grant_dc;
    assign ic_resp_valid_o    = ic_rv_q;
    assign ic_resp_data_o     = ic_rd_q;
    assign dc_resp_valid_o    = dc_rv_q;
    assign dc_resp_data_o     = dc_rd_q;
    assign mem_rd_req_valid_o = mem_rd_q;
    assign mem_wr_req_valid_o = mem_wr_q;
    assign mem_req_is_instr_o = mem_instr_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_wr_data_o      = mem_wdata_q;
    assign mem_access_size_o  = mem_size_q;
    assign err_o              = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 10-stage memory model plus a cycle-level reference of the
// arbitration, busy tracking, watchdog and error rules; directed steps then random traffic.
module tb_mem_arbiter;
    localparam int TO = 32, AW = 32, LW = 128, SW = 3;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o;
    logic [AW-1:0] ic_addr_i;
    logic [SW-1:0] ic_access_size_i;
    logic [LW-1:0] ic_resp_data_o;
    logic          dc_rd_req_valid_i, dc_wr_req_valid_i, dc_req_ready_o, dc_resp_valid_o;
    logic [AW-1:0] dc_addr_i;
    logic [LW-1:0] dc_wr_data_i, dc_resp_data_o;
    logic [SW-1:0] dc_access_size_i;
    logic          mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o;
    logic [AW-1:0] mem_address_o;
    logic [LW-1:0] mem_wr_data_o, mem_data_i;
    logic [SW-1:0] mem_access_size_o;
    logic          mem_data_valid_i, mem_data_is_instr_i, err_o;

    mem_arbiter #(.TIMEOUT(TO), .ADDR_W(AW), .LINE_W(LW), .SIZE_W(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_addr_i(ic_addr_i),
        .ic_access_size_i(ic_access_size_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
        .dc_rd_req_valid_i(dc_rd_req_valid_i), .dc_wr_req_valid_i(dc_wr_req_valid_i),
        .dc_addr_i(dc_addr_i), .dc_wr_data_i(dc_wr_data_i),
        .dc_access_size_i(dc_access_size_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o),
        .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_wr_req_valid_o(mem_wr_req_valid_o),
        .mem_req_is_instr_o(mem_req_is_instr_o), .mem_address_o(mem_address_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_access_size_o(mem_access_size_o),
        .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
        .mem_data_i(mem_data_i), .err_o(err_o)
    );

    int n_assert = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int          due;
        bit          tag;
        logic [LW-1:0] data;
    } rsp_t;
    rsp_t          rq[$];
    logic [LW-1:0] mem [logic [AW-1:0]];
    bit            mem_on = 1'b1, inj = 1'b0, inj_tag = 1'b0;

    // reference state: busy flags, grant cycle of the outstanding read, tie pointer
    bit            m_ic_busy, m_dc_busy, m_last, m_err;
    int            m_ic_since, m_dc_since;
    logic          e_rd, e_wr, e_instr, e_icv, e_dcv;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_icd, e_dcd;
    logic [SW-1:0] e_size;
    logic          obs_icr, obs_dcr;

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {4{a ^ 32'h5a5a_0000}};
    endfunction

    function automatic logic [LW-1:0] rdmem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ic_busy = 0; m_dc_busy = 0; m_last = 1; m_err = 0;
        m_ic_since = 0; m_dc_since = 0;
        e_rd = 0; e_wr = 0; e_instr = 0; e_icv = 0; e_dcv = 0;
        e_addr = '0; e_wdata = '0; e_icd = '0; e_dcd = '0; e_size = '0;
    endtask

    task automatic check_regs();
        chk("mem_rd",    LW'(mem_rd_req_valid_o), LW'(e_rd));
        chk("mem_wr",    LW'(mem_wr_req_valid_o), LW'(e_wr));
        chk("mem_instr", LW'(mem_req_is_instr_o), LW'(e_instr));
        chk("mem_addr",  LW'(mem_address_o),      LW'(e_addr));
        chk("mem_wdata", mem_wr_data_o,           e_wdata);
        chk("mem_size",  LW'(mem_access_size_o),  LW'(e_size));
        chk("ic_rv",     LW'(ic_resp_valid_o),    LW'(e_icv));
        chk("ic_rd",     ic_resp_data_o,          e_icd);
        chk("dc_rv",     LW'(dc_resp_valid_o),    LW'(e_dcv));
        chk("dc_rd",     dc_resp_data_o,          e_dcd);
        chk("err",       LW'(err_o),              LW'(m_err));
    endtask

    // One clock cycle: check registered outputs, run the memory, check and predict grants.
    task automatic tick();
        bit gi, gd, ie, de, ill, err_n;
        #1;
        check_regs();
        if (mem_wr_req_valid_o) mem[mem_address_o] = mem_wr_data_o;
        if (mem_rd_req_valid_o && mem_on)
            rq.push_back('{cyc + 10, mem_req_is_instr_o, rdmem(mem_address_o)});
        while (rq.size() > 0 && rq[0].due < cyc) rq.delete(0);
        mem_data_valid_i    = 1'b0;
        mem_data_is_instr_i = 1'($urandom);
        mem_data_i          = {4{$urandom}};
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_data_valid_i    = 1'b1;
            mem_data_is_instr_i = rq[0].tag;
            mem_data_i          = rq[0].data;
            rq.delete(0);
        end else if (inj) begin
            mem_data_valid_i    = 1'b1;
            mem_data_is_instr_i = inj_tag;
            inj = 1'b0;
        end
        #1;
        ie  = ic_req_valid_i && !m_ic_busy;
        ill = dc_rd_req_valid_i && dc_wr_req_valid_i;
        de  = !ill && ((dc_rd_req_valid_i && !m_dc_busy) || dc_wr_req_valid_i);
        gi  = ie && (!de || m_last);
        gd  = de && (!ie || !m_last);
        obs_icr = ic_req_ready_o;
        obs_dcr = dc_req_ready_o;
        chk("ic_ready", LW'(obs_icr), LW'(gi));
        chk("dc_ready", LW'(obs_dcr), LW'(gd));

        e_rd = gi || (gd && dc_rd_req_valid_i);
        e_wr = gd && dc_wr_req_valid_i;
        if (gi) begin
            e_instr = 1; e_addr = ic_addr_i; e_wdata = '0; e_size = ic_access_size_i;
        end else if (gd) begin
            e_instr = 0; e_addr = dc_addr_i; e_size = dc_access_size_i;
            e_wdata = dc_wr_req_valid_i ? dc_wr_data_i : '0;
        end
        err_n = ill;
        if (m_ic_busy && (cyc - m_ic_since) == TO) err_n = 1;
        if (m_dc_busy && (cyc - m_dc_since) == TO) err_n = 1;
        e_icv = 0; e_dcv = 0;
        if (mem_data_valid_i) begin
            if (mem_data_is_instr_i) begin
                if (m_ic_busy) begin e_icv = 1; e_icd = mem_data_i; m_ic_busy = 0; end
                else err_n = 1;
            end else begin
                if (m_dc_busy) begin e_dcv = 1; e_dcd = mem_data_i; m_dc_busy = 0; end
                else err_n = 1;
            end
        end
        if (gi) begin m_ic_busy = 1; m_ic_since = cyc; m_last = 0; end
        if (gd) begin
            m_last = 1;
            if (dc_rd_req_valid_i) begin m_dc_busy = 1; m_dc_since = cyc; end
        end
        m_err = m_err || err_n;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        ic_req_valid_i = 0; dc_rd_req_valid_i = 0; dc_wr_req_valid_i = 0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset asserted mid-cycle: outputs must drop before any clock edge.
    task automatic do_reset();
        clear_inputs();
        mem_data_valid_i = 0;
        rst_i = 1;
        #1;
        model_reset();
        check_regs();
        chk("rst_ic_ready", LW'(ic_req_ready_o), LW'(1'b0));
        chk("rst_dc_ready", LW'(dc_req_ready_o), LW'(1'b0));
        @(posedge clk_i);
        #1;
        rst_i = 0;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, first_err;
        int ic_g[$], dc_g[$];
        logic [LW-1:0] d;

        rst_i = 1; clear_inputs();
        ic_addr_i = '0; ic_access_size_i = '0; dc_addr_i = '0; dc_wr_data_i = '0;
        dc_access_size_i = '0; mem_data_valid_i = 0; mem_data_is_instr_i = 0; mem_data_i = '0;
        model_reset();
        #3;
        check_regs();
        @(posedge clk_i); #1;
        rst_i = 0;
        cyc = 0;

        // single icache read
        ic_req_valid_i = 1; ic_addr_i = 32'h100; ic_access_size_i = 3'd2;
        t0 = cyc;
        tick();
        chk("t2_ready", LW'(obs_icr), LW'(1'b1));
        ic_req_valid_i = 0;
        chk("t2_memrd", LW'(mem_rd_req_valid_o), LW'(1'b1));
        chk("t2_instr", LW'(mem_req_is_instr_o), LW'(1'b1));
        chk("t2_addr",  LW'(mem_address_o), LW'(32'h100));
        for (int i = 0; i < 20 && !ic_resp_valid_o; i++) tick();
        chk("t2_latency", LW'(cyc - t0), LW'(12));
        chk("t2_data", ic_resp_data_o, pat(32'h100));
        chk("t2_dcv", LW'(dc_resp_valid_o), LW'(1'b0));

        // both caches contend; first tie to icache, then alternation
        do_reset();
        ic_req_valid_i = 1; ic_addr_i = 32'h140;
        dc_rd_req_valid_i = 1; dc_addr_i = 32'h180; dc_access_size_i = 3'd1;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obs_icr) begin ic_g.push_back(cyc - 1); ic_addr_i = ic_addr_i + 32'h40; end
            if (obs_dcr) begin dc_g.push_back(cyc - 1); dc_addr_i = dc_addr_i + 32'h40; end
        end
        chk("t3_nic", LW'(ic_g.size()), LW'(4));
        chk("t3_ndc", LW'(dc_g.size()), LW'(4));
        if (ic_g.size() >= 2 && dc_g.size() >= 2) begin
            chk("t3_ic0",  LW'(ic_g[0] - t0), LW'(0));
            chk("t3_dc0",  LW'(dc_g[0] - t0), LW'(1));
            chk("t3_ic1",  LW'(ic_g[1] - ic_g[0]), LW'(12));
            chk("t3_dc1",  LW'(dc_g[1] - dc_g[0]), LW'(12));
        end
        idle(16);

        // write then read same line
        d = {4{32'hcafe_f00d}};
        dc_wr_req_valid_i = 1; dc_addr_i = 32'h200; dc_wr_data_i = d;
        t0 = cyc;
        tick();
        chk("t4_wgrant", LW'(obs_dcr), LW'(1'b1));
        dc_wr_req_valid_i = 0; dc_rd_req_valid_i = 1;
        chk("t4_memwr", LW'(mem_wr_req_valid_o), LW'(1'b1));
        chk("t4_wdata", mem_wr_data_o, d);
        tick();
        chk("t4_rgrant", LW'(obs_dcr), LW'(1'b1));
        dc_rd_req_valid_i = 0;
        for (int i = 0; i < 20 && !dc_resp_valid_o; i++) tick();
        chk("t4_latency", LW'(cyc - t0), LW'(13));
        chk("t4_data", dc_resp_data_o, d);

        // writeback while a dcache read is outstanding
        dc_rd_req_valid_i = 1; dc_addr_i = 32'h300;
        t0 = cyc;
        tick();
        dc_rd_req_valid_i = 0; dc_wr_req_valid_i = 1; dc_addr_i = 32'h340;
        dc_wr_data_i = {4{32'h1234_5678}};
        tick();
        chk("t5_wr_busy", LW'(obs_dcr), LW'(1'b1));
        dc_wr_req_valid_i = 0;
        for (int i = 0; i < 20 && !dc_resp_valid_o; i++) tick();
        chk("t5_latency", LW'(cyc - t0), LW'(12));
        chk("t5_data", dc_resp_data_o, pat(32'h300));

        // unexpected response
        idle(2);
        inj = 1; inj_tag = 0;
        tick();
        chk("t6_nodcv", LW'(dc_resp_valid_o), LW'(1'b0));
        chk("t6_err", LW'(err_o), LW'(1'b1));
        idle(3);
        chk("t6_sticky", LW'(err_o), LW'(1'b1));
        do_reset();
        chk("t6_cleared", LW'(err_o), LW'(1'b0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!ic_req_valid_i && $urandom_range(0, 2) == 0) begin
                ic_req_valid_i = 1;
                ic_addr_i = AW'($urandom_range(0, 7)) << 6;
                ic_access_size_i = SW'($urandom);
            end
            if (!dc_rd_req_valid_i && !dc_wr_req_valid_i && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) dc_rd_req_valid_i = 1;
                else dc_wr_req_valid_i = 1;
                dc_addr_i = AW'($urandom_range(0, 7)) << 6;
                dc_wr_data_i = {$urandom, $urandom, $urandom, $urandom};
                dc_access_size_i = SW'($urandom);
            end
            tick();
            if (obs_icr) ic_req_valid_i = 0;
            if (obs_dcr) begin dc_rd_req_valid_i = 0; dc_wr_req_valid_i = 0; end
        end
        idle(15);
        chk("rand_noerr", LW'(err_o), LW'(1'b0));

        // watchdog, illegal pair, mid-operation reset
        mem_on = 0;
        ic_req_valid_i = 1; ic_addr_i = 32'h400;
        t0 = cyc;
        tick();
        ic_req_valid_i = 0;
        first_err = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err_o && first_err < 0) first_err = cyc;
        end
        chk("t7_timeout", LW'(first_err - t0), LW'(TO + 1));
        dc_rd_req_valid_i = 1; dc_wr_req_valid_i = 1; dc_addr_i = 32'h480;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t7_illegal", LW'(obs_dcr), LW'(1'b0));
        end
        clear_inputs();
        mem_on = 1;
        dc_rd_req_valid_i = 1; dc_addr_i = 32'h440;
        tick();
        dc_rd_req_valid_i = 0;
        tick(); tick();
        do_reset();
        idle(12);
        chk("t7_late_resp_err", LW'(err_o), LW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
